// File: rtl/llr_input_loader.sv
// Channel LLR front-end loader: accepts LANES saturated LLRs per beat, assembles a
// zero-padded 128-entry row, and writes it to the alpha memory in one cycle.
module llr_input_loader #(
  parameter int BITWIDTH_IN      = 8,
  parameter int BITWIDTH_LLRS    = 7,
  parameter int BITWIDTH_ADDRESS = 2,
  parameter int LANES            = 8,
  parameter int ADDR_CHANNEL     = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [1:0]                        size_i,
  input  logic                              llr_valid_i,
  output logic                              llr_ready_o,
  input  logic [LANES*BITWIDTH_IN-1:0]      llr_i,
  output logic                              wr_o,
  output logic [BITWIDTH_ADDRESS-1:0]       address_o,
  output logic [128*BITWIDTH_LLRS-1:0]      data_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int ROW   = 128;
  localparam int CNT_W = 8;

  localparam logic signed [BITWIDTH_LLRS-1:0] LLR_MAX = {1'b0, {(BITWIDTH_LLRS-1){1'b1}}};
  localparam logic signed [BITWIDTH_LLRS-1:0] LLR_MIN = -LLR_MAX;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                       state, state_next;
  logic [CNT_W-1:0]             cnt, beats;
  logic [ROW*BITWIDTH_LLRS-1:0] buffer;
  logic                         accept, last_beat;

  // Symmetric clamp: the most negative code is never produced, so -64 maps to -63.
  function automatic logic signed [BITWIDTH_LLRS-1:0] saturate(
    input logic signed [BITWIDTH_IN-1:0] x
  );
    int xi;
    xi = int'(x);
    if (xi > int'(LLR_MAX))      return LLR_MAX;
    else if (xi < int'(LLR_MIN)) return LLR_MIN;
    else                         return x[BITWIDTH_LLRS-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] beats_for(input logic [1:0] size);
    case (size)
      2'd0:    return CNT_W'(32 / LANES);
      2'd1:    return CNT_W'(64 / LANES);
      default: return CNT_W'(ROW / LANES);
    endcase
  endfunction

  assign accept    = (state == LOAD) && llr_valid_i;
  assign last_beat = (cnt == beats - CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = LOAD;
      LOAD:    if (accept && last_beat) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clearing on start is what zero-pads short frames and stops stale data leaking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buffer <= '0;
      cnt    <= '0;
      beats  <= '0;
    end else if (state == IDLE && start_i) begin
      buffer <= '0;
      cnt    <= '0;
      beats  <= beats_for(size_i);
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        buffer[(int'(cnt)*LANES + k)*BITWIDTH_LLRS +: BITWIDTH_LLRS] <=
          saturate(llr_i[k*BITWIDTH_IN +: BITWIDTH_IN]);
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign llr_ready_o = (state == LOAD);
  assign wr_o        = (state == WRITE);
  assign done_o      = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign address_o   = BITWIDTH_ADDRESS'(ADDR_CHANNEL);
  assign data_o      = buffer;

endmodule

// File: tb/tb_llr_input_loader.sv
// Bench for llr_input_loader: table-driven saturation vectors, directed corner
// sequences, and randomized frames checked against an array-based row model.
module tb_llr_input_loader;

  localparam int W_IN  = 8;
  localparam int W_LLR = 7;
  localparam int LANES = 8;
  localparam int ROW   = 128;

  logic                   clk = 1'b0;
  logic                   rst, start, llr_valid, llr_ready, wr, busy, done;
  logic [1:0]             size, address;
  logic [LANES*W_IN-1:0]  llr;
  logic [ROW*W_LLR-1:0]   data;

  always #5 clk = ~clk;

  llr_input_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .size_i      (size),
    .llr_valid_i (llr_valid),
    .llr_ready_o (llr_ready),
    .llr_i       (llr),
    .wr_o        (wr),
    .address_o   (address),
    .data_o      (data),
    .busy_o      (busy),
    .done_o      (done)
  );

  int checks = 0;
  int errors = 0;
  int frame_vals[ROW];

  typedef struct {
    int in_val;
    int exp_val;
  } sat_vec_t;
  sat_vec_t sat_tab[12];

  int r_wr_cnt, r_done_cnt, r_wr_cyc, r_done_cyc, r_idle_cyc, r_acc, r_last_acc;
  logic [ROW*W_LLR-1:0] r_row;

  function automatic int sat_ref(input int v);
    if (v > 63)  return 63;
    if (v < -63) return -63;
    return v;
  endfunction

  function automatic int size_n(input logic [1:0] sz);
    return (sz == 2'd0) ? 32 : (sz == 2'd1) ? 64 : 128;
  endfunction

  function automatic int entry(input logic [ROW*W_LLR-1:0] r, input int i);
    logic signed [W_LLR-1:0] e;
    e = r[i*W_LLR +: W_LLR];
    return int'(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_beat(input int b);
    for (int k = 0; k < LANES; k++) llr[k*W_IN +: W_IN] = W_IN'(frame_vals[b*LANES + k]);
  endtask

  // mode: 0 continuous valid, 1 valid pattern 1-0-0, 2 random valid.
  // poke: pulse start during LOAD (cycle 3) and in the DONE cycle.
  task automatic run_frame(input logic [1:0] sz, input int mode, input bit poke);
    int beats, b;
    bit v, finished;
    beats = size_n(sz) / LANES;
    r_wr_cnt = 0; r_done_cnt = 0; r_wr_cyc = -1; r_done_cyc = -1;
    r_idle_cyc = -1; r_last_acc = -1; r_row = '0;
    @(negedge clk);
    start = 1'b1; size = sz; llr_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; b = 0; finished = 1'b0;
    for (int c = 1; c <= 400 && !finished; c++) begin
      if (wr)   begin r_wr_cnt++;   r_wr_cyc = c; r_row = data; end
      if (done) begin r_done_cnt++; r_done_cyc = c; end
      if (!busy) begin
        r_idle_cyc = c; finished = 1'b1; start = 1'b0; llr_valid = 1'b0;
      end else begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ((c - 1) % 3 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (b < beats) drive_beat(b);
        else           llr = {$urandom, $urandom};
        llr_valid = v;
        start = poke && (c == 3 || done);
        if (v && llr_ready) begin b++; r_last_acc = c; end
        @(negedge clk);
      end
    end
    r_acc = b;
    if (!finished) check("frame_timeout", 0, 1);
    if (poke) begin
      @(negedge clk);
      check("start_in_done_ignored_busy", int'(busy), 0);
    end
  endtask

  task automatic check_frame(input string tag, input logic [1:0] sz, input bit rows);
    int n;
    n = size_n(sz);
    check({tag, "_beats"},      r_acc, n / LANES);
    check({tag, "_wr_count"},   r_wr_cnt, 1);
    check({tag, "_done_count"}, r_done_cnt, 1);
    check({tag, "_wr_cycle"},   r_wr_cyc, r_last_acc + 1);
    check({tag, "_done_cycle"}, r_done_cyc, r_last_acc + 2);
    check({tag, "_idle_cycle"}, r_idle_cyc, r_last_acc + 3);
    if (rows)
      for (int i = 0; i < ROW; i++)
        check($sformatf("%s_row[%0d]", tag, i), entry(r_row, i),
              (i < n) ? sat_ref(frame_vals[i]) : 0);
  endtask

  initial begin
    sat_tab[0]  = '{127, 63};  sat_tab[1]  = '{64, 63};    sat_tab[2]  = '{63, 63};
    sat_tab[3]  = '{-63, -63}; sat_tab[4]  = '{-64, -63};  sat_tab[5]  = '{-128, -63};
    sat_tab[6]  = '{0, 0};     sat_tab[7]  = '{-1, -1};    sat_tab[8]  = '{62, 62};
    sat_tab[9]  = '{-62, -62}; sat_tab[10] = '{100, 63};   sat_tab[11] = '{-100, -63};

    rst = 1'b1; start = 1'b0; size = 2'd0; llr_valid = 1'b0; llr = '0;

    // Reset then idle
    repeat (2) @(negedge clk);
    check("reset_wr",      int'(wr), 0);
    check("reset_done",    int'(done), 0);
    check("reset_busy",    int'(busy), 0);
    check("reset_ready",   int'(llr_ready), 0);
    check("reset_address", int'(address), 0);
    check("reset_data_zero", int'(data == '0), 1);
    rst = 1'b0;
    begin
      int wrs, dns;
      wrs = 0; dns = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wr) wrs++;
        if (done) dns++;
      end
      check("idle_no_wr", wrs, 0);
      check("idle_no_done", dns, 0);
      check("idle_busy", int'(busy), 0);
    end

    // start together with reset is dropped
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("start_with_rst_busy", int'(busy), 0);
    @(negedge clk);
    check("start_with_rst_busy2", int'(busy), 0);

    // Full 128 frame, continuous valid
    for (int i = 0; i < ROW; i++) frame_vals[i] = i % 50;
    run_frame(2'd2, 0, 1'b0);
    check_frame("full", 2'd2, 1'b1);
    check("full_abs_wr_cycle", r_wr_cyc, 17);
    check("full_abs_done_cycle", r_done_cyc, 18);
    check("full_abs_idle_cycle", r_idle_cyc, 19);

    // Short frame after a full frame of +20
    for (int i = 0; i < ROW; i++) frame_vals[i] = 20;
    run_frame(2'd2, 0, 1'b0);
    check_frame("pre20", 2'd2, 1'b1);
    for (int i = 0; i < ROW; i++) frame_vals[i] = -5;
    run_frame(2'd0, 0, 1'b0);
    check_frame("short", 2'd0, 1'b1);

    // Saturation table
    for (int i = 0; i < ROW; i++) frame_vals[i] = sat_tab[i % 12].in_val;
    run_frame(2'd0, 0, 1'b0);
    check_frame("sat", 2'd0, 1'b0);
    for (int i = 0; i < 32; i++)
      check($sformatf("sat_row[%0d]_in%0d", i, sat_tab[i % 12].in_val),
            entry(r_row, i), sat_tab[i % 12].exp_val);

    // Backpressure with ignored starts
    for (int i = 0; i < ROW; i++) frame_vals[i] = int'($urandom_range(0, 255)) - 128;
    run_frame(2'd2, 1, 1'b1);
    check_frame("bp", 2'd2, 1'b1);

    // Mid-frame reset after 9 beats
    for (int i = 0; i < ROW; i++) frame_vals[i] = 33;
    begin
      int wrs;
      wrs = 0;
      @(negedge clk);
      start = 1'b1; size = 2'd2;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < 9; b++) begin
        drive_beat(b); llr_valid = 1'b1;
        @(negedge clk);
        if (wr) wrs++;
      end
      drive_beat(9); rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; llr_valid = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_ready", int'(llr_ready), 0);
      check("midrst_data_zero", int'(data == '0), 1);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wr) wrs++;
      end
      check("midrst_no_wr", wrs, 0);
    end
    for (int i = 0; i < ROW; i++) frame_vals[i] = int'($urandom_range(0, 255)) - 128;
    run_frame(2'd1, 0, 1'b0);
    check_frame("after_rst", 2'd1, 1'b1);

    // Randomized frames
    for (int t = 0; t < 6; t++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      for (int i = 0; i < ROW; i++) frame_vals[i] = int'($urandom_range(0, 255)) - 128;
      run_frame(sz, 2, 1'($urandom_range(0, 1)));
      check_frame($sformatf("rand%0d", t), sz, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llr_input_loader.md
# llr_input_loader

Front-end loader for the polar decoder's channel LLR memory. It accepts a frame of channel LLRs as a stream of fixed-width beats over a valid/ready handshake. Each LLR is saturated to the internal LLR width, and the beats are assembled into one 128-entry row, with unused entries zero-padded for shorter blocks. The block then issues a single-cycle write of that row into the alpha memory row that holds channel LLRs, and signals completion to the decoder controller.

## Interface
- BITWIDTH_IN, 8: width of each incoming signed LLR.
- BITWIDTH_LLRS, 7: width of each stored signed LLR.
- BITWIDTH_ADDRESS, 2: alpha memory address width.
- LANES, 8: LLRs per input beat; must be a power of two, 1..32.
- ADDR_CHANNEL, 0: alpha memory row that receives channel LLRs.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  pulse that begins a frame; only honoured in IDLE.
- size_i  in  2  block size, latched on an accepted start_i: 0→32, 1→64, 2→128, 3→128.
- llr_valid_i  in  1  input beat valid.
- llr_ready_o  out  1  loader accepts a beat.
- llr_i  in  LANES×BITWIDTH_IN  signed LLRs; lane k maps to index beat·LANES+k.
- wr_o  out  1  alpha memory write enable.
- address_o  out  BITWIDTH_ADDRESS  alpha memory address.
- data_o  out  128×BITWIDTH_LLRS  assembled row.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  single-cycle pulse after the row write.

## Operation
- State machine: IDLE, LOAD, WRITE, DONE.
- IDLE to LOAD:
  - Taken on start_i.
  - Latches the beat count: N/LANES, where N = 32, 64 or 128 from size_i.
  - Clears the assembly buffer to all zeros and the beat counter to 0.
- In LOAD:
  - llr_ready_o = 1.
  - On llr_valid_i & llr_ready_o, the saturated lanes are written to buffer[cnt·LANES +: LANES] and cnt increments.
  - On acceptance of the last beat (cnt = beats−1), go to WRITE.
  - Stalls (llr_valid_i low) hold state and cnt indefinitely.
- WRITE:
  - wr_o = 1 for exactly one cycle, address_o = ADDR_CHANNEL, data_o = buffer.
  - Then go to DONE.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- Saturation:
  - Each input is signed BITWIDTH_IN.
  - The output range is symmetric: ±(2^(BITWIDTH_LLRS−1)−1), i.e. ±63 at defaults.
  - Values above +63 become +63; values below −63 (including −64) become −63.
  - In-range values pass through unchanged.
  - The same symmetric clamp applies when BITWIDTH_IN = BITWIDTH_LLRS.
- Zero padding:
  - Entries at index ≥ N remain 0, because the buffer is cleared on start.
  - Nothing from a previous frame leaks into a new frame.
- start_i is ignored in LOAD, WRITE and DONE; a new frame is not queued.
- llr_valid_i is ignored outside LOAD; llr_ready_o is 0 there.
- data_o:
  - Continuously drives the buffer register.
  - It is only meaningful while wr_o = 1.
  - address_o is driven to ADDR_CHANNEL at all times.

## Timing
- Reset values: state IDLE, buffer 0, cnt 0, wr_o 0, done_o 0, busy_o 0, llr_ready_o 0, data_o 0, address_o ADDR_CHANNEL.
- llr_ready_o, wr_o, busy_o and done_o are decoded from the registered state only; there is no combinational path from inputs.
- Cycle numbering: start_i is sampled at edge 0.
  - LOAD occupies cycles 1 … .
  - With continuous valid, the 128-entry frame at LANES = 8 accepts beats in cycles 1–16.
  - WRITE falls in cycle 17, DONE in cycle 18, IDLE in cycle 19.
- Minimum frame latency, start to done_o: beats + 2 cycles.
- Memory contents are readable by the decoder in the DONE cycle.
- Reset mid-operation has priority over every other event:
  - The state returns to IDLE and the buffer is cleared.
  - The partial frame is discarded and no wr_o is issued.
- A start_i asserted in the same cycle as rst_i is ignored.
- start_i in the DONE cycle is ignored; software must re-issue it in IDLE.

## Test plan
- Reset then idle:
  - Stimulus: rst_i held for 2 cycles, then released with no stimulus.
  - Required: all outputs at reset values; no wr_o or done_o for 20 cycles.
- Full 128-entry frame, continuous valid, LANES = 8:
  - Stimulus: lane value = index mod 50.
  - Required: wr_o exactly at cycle 17, data_o[i] = i mod 50, done_o at cycle 18, busy_o low at cycle 19.
- Short frame:
  - Stimulus: size_i = 0 (N = 32), all LLRs = −5, preceded by a 128-entry frame of +20.
  - Required: 4 beats accepted, data_o[0..31] = −5, data_o[32..127] = 0.
- Saturation:
  - Stimulus: lanes driven with +127, +64, +63, −63, −64, −128, 0, −1.
  - Required: stored values +63, +63, +63, −63, −63, −63, 0, −1.
- Backpressure and ignored start:
  - Stimulus: valid toggled 1-0-0-1…; start_i pulsed during LOAD.
  - Required: exactly 16 beats captured in order; the frame is unaffected; a single wr_o and a single done_o.
- Mid-frame reset:
  - Stimulus: rst_i pulsed after beat 9, followed by a fresh 64-entry frame.
  - Required: no wr_o for the aborted frame; the new row holds only new data, with entries 64–127 = 0.
